servo_pwm_capture: RTL and testbench
====================================

// Module: servo_pwm_capture
// PURPOSE
//  Multi-channel servo-PWM pulse-width decoder; the receive-side counterpart of the servo pulse generators.
//  Measures the high time of each incoming 50 Hz servo-style pulse train (RC receiver or loop-back) in CLOCK_50 cycles.
//  Publishes each validated width with a one-cycle strobe, and flags out-of-range pulses and lost signals.
//  Sits between the external PWM inputs and the arm control logic, which consumes widths as position commands.
// PARAMETERS
//  NCH            4          number of input channels
//  PW             17         width-counter / width-output bits per channel
//  FILT           4          consecutive equal samples required before the filtered level changes (>=1)
//  MIN_PULSE      50_000     shortest accepted pulse, cycles (1.0 ms)
//  MAX_PULSE      100_000    longest accepted pulse, cycles (2.0 ms)
//  DEFAULT_WIDTH  62_500     width_out value after reset
//  FRAME_TIMEOUT  1_500_000  cycles without a filtered rising edge before signal loss (30 ms)
// PORTS
//  CLOCK_50     in   1        50 MHz system clock
//  rst          in   1        synchronous, active-high reset
//  pwm_in       in   NCH      asynchronous servo PWM inputs
//  width_out    out  NCH*PW   last accepted width per channel; ch k occupies [k*PW +: PW]
//  width_valid  out  NCH      one-cycle strobe; width_out[k] updated this cycle
//  range_err    out  NCH      one-cycle strobe; pulse ended outside [MIN_PULSE, MAX_PULSE]
//  signal_ok    out  NCH      level; 1 while the channel receives valid frames
// BEHAVIOUR
//  Reset (all registered): width_out=DEFAULT_WIDTH, width_valid=0, range_err=0, signal_ok=0, FSM=S_SYNC, counters=0.
//  Input path per channel: 2-FF synchronizer -> glitch filter.
//   Filtered level toggles only after FILT consecutive samples differ from it; filter reset level is 0.
//   Rise and fall are delayed equally, so measured width = true width (+/-1 cycle).
//  FSM per channel:
//   S_SYNC: wait for filtered level 0, then go to S_LOW. Discards any partial pulse present at reset.
//   S_LOW: on filtered rise -> S_HIGH, wcnt<=1, tcnt<=0.
//   S_HIGH: wcnt increments each cycle; saturates at 2^PW-1 (no wrap). On filtered fall -> S_LOW and evaluate wcnt:
//    MIN_PULSE<=wcnt<=MAX_PULSE: width_out<=wcnt, width_valid=1 for one cycle, signal_ok<=1.
//    otherwise: range_err=1 for one cycle; width_out unchanged.
//  Latency: width_valid/range_err assert exactly FILT+3 cycles after the first pwm_in sample of the falling edge.
//  Timeout: tcnt counts in S_LOW and S_HIGH and clears on each filtered rise.
//   When tcnt reaches FRAME_TIMEOUT: signal_ok<=0, FSM -> S_SYNC; width_out holds its last value.
//   Stuck-high input times out the same way, with no strobe.
//   A timeout and a fall in the same cycle: timeout wins; no valid or err strobe.
//  width_valid and range_err are never both high on one channel. Channels are fully independent.
//  rst asserted mid-pulse: everything returns to reset values; that pulse is never reported.
// STRUCTURE
//  Shared package servo_pkg holds: PW, PULSE_MIN=50_000, PULSE_MAX, CENTER=62_500, FRAME_TIMEOUT, and the FSM state enum.
//   The pulse generators reuse the same constants.
//  Sub-module pwm_capture_ch contains synchronizer, filter, FSM and counters for one channel.
//   The top instantiates NCH copies in a generate loop and concatenates the outputs.
// TESTING
//  1. ch0 high 75_000 cycles in a 1_000_000-cycle frame:
//     width_valid[0] one cycle at fall+FILT+3; width_out[0]=75_000 (+/-1); signal_ok[0]=1.
//  2. 2-cycle glitch with FILT=4, pin otherwise low: no state change, no strobes, width_out=62_500.
//  3. 40_000-cycle pulse, then a 120_000-cycle pulse: range_err[0] strobes twice; width_out unchanged; no width_valid.
//  4. Valid frames, then input held low: signal_ok drops exactly FRAME_TIMEOUT cycles after the last filtered rise;
//     width_out holds.
//  5. rst pulsed 30_000 cycles into a 75_000 pulse: no strobe for that pulse;
//     next full 60_000 pulse -> width_out=60_000.
//  6. All 4 channels with 50_000 / 62_500 / 87_500 / 100_000 pulses, staggered phases:
//     each width_out correct, strobes independent, no cross-talk.
//  Also: input held high beyond FRAME_TIMEOUT -> signal_ok=0, no strobes, FSM back in S_SYNC.

Source files
------------

// File: rtl/servo_pwm_capture_pkg.sv
// Shared constants and state type for the servo PWM generators and the capture block.
package servo_pkg;

   localparam int unsigned PW            = 17;
   localparam int unsigned PULSE_MIN     = 50_000;
   localparam int unsigned PULSE_MAX     = 100_000;
   localparam int unsigned CENTER        = 62_500;
   localparam int unsigned FRAME_TIMEOUT = 1_500_000;
   localparam int unsigned FILT_DEPTH    = 4;

   typedef enum logic [1:0] {
      S_SYNC = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } state_t;

   function automatic logic width_in_range(input int unsigned w,
                                           input int unsigned lo,
                                           input int unsigned hi);
      return (w >= lo) && (w <= hi);
   endfunction

endpackage

// File: rtl/servo_pwm_capture_ch.sv
// One capture channel: synchronizer, glitch filter, edge detect, width/timeout FSM.
module pwm_capture_ch #(
   parameter int unsigned PW            = servo_pkg::PW,
   parameter int unsigned FILT          = servo_pkg::FILT_DEPTH,
   parameter int unsigned MIN_PULSE     = servo_pkg::PULSE_MIN,
   parameter int unsigned MAX_PULSE     = servo_pkg::PULSE_MAX,
   parameter int unsigned DEFAULT_WIDTH = servo_pkg::CENTER,
   parameter int unsigned FRAME_TIMEOUT = servo_pkg::FRAME_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm,
   output logic [PW-1:0] width,
   output logic          valid,
   output logic          err,
   output logic          ok
);
   import servo_pkg::*;

   localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam int unsigned TW = $clog2(FRAME_TIMEOUT);
   localparam logic [FW-1:0] FLAST = FW'(FILT - 1);
   localparam logic [TW-1:0] TLAST = TW'(FRAME_TIMEOUT - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    primed;
   logic          filt;
   logic [FW-1:0] fcnt;
   logic          filt_q;
   logic          rise_q;
   logic          fall_q;
   state_t        state;
   logic [PW-1:0] wcnt;
   logic [TW-1:0] tcnt;

   // Two-flop synchronizer; primed marks when sync2 holds a real post-reset sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         primed <= '0;
      end else begin
         sync1  <= pwm;
         sync2  <= sync1;
         primed <= {primed[0], 1'b1};
      end
   end

   // Glitch filter: level follows sync2 only after FILT consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= 1'b0;
         fcnt <= '0;
      end else if (sync2 != filt) begin
         if (fcnt == FLAST) begin
            filt <= sync2;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end else begin
         fcnt <= '0;
      end
   end

   // Registered edge events of the filtered level; rise and fall see identical delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         filt_q <= filt;
         rise_q <= filt & ~filt_q;
         fall_q <= ~filt & filt_q;
      end
   end

   // Width measurement, range check and frame timeout; timeout takes priority over a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_SYNC;
         wcnt  <= '0;
         tcnt  <= '0;
         width <= PW'(DEFAULT_WIDTH);
         valid <= 1'b0;
         err   <= 1'b0;
         ok    <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_SYNC: begin
               // Leave only once the pin is genuinely sampled low with no pending filter change,
               // so a pulse already in progress at reset is never measured.
               tcnt <= '0;
               if (primed[1] && !sync2 && !filt && (fcnt == '0)) begin
                  state <= S_LOW;
               end
            end
            S_LOW, S_HIGH: begin
               if (tcnt == TLAST) begin
                  ok    <= 1'b0;
                  tcnt  <= '0;
                  state <= S_SYNC;
               end else if (state == S_LOW) begin
                  if (rise_q) begin
                     state <= S_HIGH;
                     wcnt  <= PW'(1);
                     tcnt  <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
                  if (fall_q) begin
                     state <= S_LOW;
                     if (width_in_range(32'(wcnt), MIN_PULSE, MAX_PULSE)) begin
                        width <= wcnt;
                        valid <= 1'b1;
                        ok    <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (wcnt != '1) begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            default: state <= S_SYNC;
         endcase
      end
   end

endmodule

// File: rtl/servo_pwm_capture.sv
// Multi-channel servo PWM pulse-width decoder; one independent capture channel per input.
module servo_pwm_capture #(
   parameter int unsigned NCH           = 4,
   parameter int unsigned PW            = servo_pkg::PW,
   parameter int unsigned FILT          = servo_pkg::FILT_DEPTH,
   parameter int unsigned MIN_PULSE     = servo_pkg::PULSE_MIN,
   parameter int unsigned MAX_PULSE     = servo_pkg::PULSE_MAX,
   parameter int unsigned DEFAULT_WIDTH = servo_pkg::CENTER,
   parameter int unsigned FRAME_TIMEOUT = servo_pkg::FRAME_TIMEOUT
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic [NCH-1:0]    pwm_in,
   output logic [NCH*PW-1:0] width_out,
   output logic [NCH-1:0]    width_valid,
   output logic [NCH-1:0]    range_err,
   output logic [NCH-1:0]    signal_ok
);
   import servo_pkg::*;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      pwm_capture_ch #(
         .PW            (PW),
         .FILT          (FILT),
         .MIN_PULSE     (MIN_PULSE),
         .MAX_PULSE     (MAX_PULSE),
         .DEFAULT_WIDTH (DEFAULT_WIDTH),
         .FRAME_TIMEOUT (FRAME_TIMEOUT)
      ) u_ch (
         .clk   (CLOCK_50),
         .rst   (rst),
         .pwm   (pwm_in[k]),
         .width (width_out[k*PW +: PW]),
         .valid (width_valid[k]),
         .err   (range_err[k]),
         .ok    (signal_ok[k])
      );
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Scoreboard bench for servo_pwm_capture with time-scaled limits (1 ms -> 500 cycles).
module tb_servo_pwm_capture;

   localparam int unsigned NCH  = 4;
   localparam int unsigned PW   = 17;
   localparam int unsigned FILT = 4;
   localparam int unsigned MINP = 500;
   localparam int unsigned MAXP = 1000;
   localparam int unsigned DEFW = 625;
   localparam int unsigned FT   = 3000;
   // drive at negedge n -> first sample edge n+1 -> strobe visible FILT+3 edges later
   localparam int unsigned LAT  = FILT + 4;

   logic              CLOCK_50 = 1'b0;
   logic              rst      = 1'b1;
   logic [NCH-1:0]    pwm_in   = '0;
   logic [NCH*PW-1:0] width_out;
   logic [NCH-1:0]    width_valid;
   logic [NCH-1:0]    range_err;
   logic [NCH-1:0]    signal_ok;

   servo_pwm_capture #(
      .NCH           (NCH),
      .PW            (PW),
      .FILT          (FILT),
      .MIN_PULSE     (MINP),
      .MAX_PULSE     (MAXP),
      .DEFAULT_WIDTH (DEFW),
      .FRAME_TIMEOUT (FT)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .width_out   (width_out),
      .width_valid (width_valid),
      .range_err   (range_err),
      .signal_ok   (signal_ok)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int unsigned cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct {
      bit          err;
      int unsigned w;
      int unsigned at;
   } ev_t;

   ev_t         evq   [NCH][$];
   int unsigned dropq [NCH][$];
   int unsigned hold      [NCH];
   int unsigned last_rise [NCH];
   bit          ok_model  [NCH];
   bit          ok_prev   [NCH];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int ch, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s ch%0d at cycle %0d: got %0d expected %0d", name, ch, cyc, act, exp);
      end
   endtask

   function automatic int unsigned width_of(input int ch);
      return int'(width_out[ch*PW +: PW]);
   endfunction

   // Drive one high pulse of w cycles on channel ch, queue the expected strobe, then idle for tail.
   task automatic pulse(input int ch, input int unsigned w, input int unsigned tail);
      ev_t e;
      pwm_in[ch]    = 1'b1;
      last_rise[ch] = cyc + LAT;
      repeat (w) @(negedge CLOCK_50);
      pwm_in[ch] = 1'b0;
      e.err = !((w >= MINP) && (w <= MAXP));
      e.at  = cyc + LAT;
      e.w   = e.err ? hold[ch] : w;
      evq[ch].push_back(e);
      if (!e.err) begin
         hold[ch]     = w;
         ok_model[ch] = 1'b1;
      end
      repeat (tail) @(negedge CLOCK_50);
   endtask

   // Every channel currently reporting signal_ok is expected to time out FT cycles after its last rise.
   task automatic expect_timeouts();
      for (int k = 0; k < NCH; k++) begin
         if (ok_model[k]) begin
            dropq[k].push_back(last_rise[k] + FT);
            ok_model[k] = 1'b0;
         end
      end
   endtask

   initial begin
      #(60000 * 20);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < NCH; k++) begin
         hold[k]      = DEFW;
         last_rise[k] = 0;
         ok_model[k]  = 1'b0;
         ok_prev[k]   = 1'b0;
      end

      // monitor: pops the scoreboard whenever a channel strobes or drops signal_ok
      fork
         forever begin
            @(negedge CLOCK_50);
            for (int k = 0; k < NCH; k++) begin
               if (width_valid[k] || range_err[k]) begin
                  chk("strobe exclusive", k, width_valid[k] & range_err[k], 0);
                  chk("strobe expected", k, evq[k].size() != 0, 1);
                  if (evq[k].size() != 0) begin
                     ev_t e;
                     e = evq[k].pop_front();
                     chk("strobe is range_err", k, range_err[k], e.err);
                     chk("strobe cycle", k, cyc, e.at);
                     chk("width_out at strobe", k, width_of(k), e.w);
                     if (!e.err) chk("signal_ok at valid", k, signal_ok[k], 1);
                  end
               end
               if (ok_prev[k] && !signal_ok[k]) begin
                  chk("signal_ok drop expected", k, dropq[k].size() != 0, 1);
                  if (dropq[k].size() != 0) begin
                     int unsigned d;
                     d = dropq[k].pop_front();
                     chk("signal_ok drop cycle", k, cyc, d);
                  end
               end
               ok_prev[k] = signal_ok[k];
            end
         end
      join_none

      // reset state
      repeat (5) @(negedge CLOCK_50);
      for (int k = 0; k < NCH; k++) chk("reset width_out", k, width_of(k), DEFW);
      chk("reset width_valid", 0, width_valid, 0);
      chk("reset range_err", 0, range_err, 0);
      chk("reset signal_ok", 0, signal_ok, 0);
      rst = 1'b0;
      repeat (10) @(negedge CLOCK_50);

      // 1: valid frames on ch0
      pulse(0, 750, 750);
      pulse(0, 600, 900);
      chk("signal_ok after valid", 0, signal_ok[0], 1);

      // 2: two-cycle glitch on idle ch1
      pwm_in[1] = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      pwm_in[1] = 1'b0;
      repeat (50) @(negedge CLOCK_50);
      chk("glitch width_out", 1, width_of(1), DEFW);
      chk("glitch signal_ok", 1, signal_ok[1], 0);

      // 3: short then long pulse -> two range errors, width held
      pulse(0, 400, 1100);
      pulse(0, 1200, 500);
      chk("width held after errors", 0, width_of(0), 600);

      // 4: input held low -> timeout
      expect_timeouts();
      repeat (FT + 200) @(negedge CLOCK_50);
      chk("signal_ok after timeout", 0, signal_ok[0], 0);
      chk("width held after timeout", 0, width_of(0), 600);

      // 5: reset in the middle of a pulse
      pulse(0, 800, 400);
      pwm_in[0] = 1'b1;
      repeat (300) @(negedge CLOCK_50);
      for (int k = 0; k < NCH; k++) begin
         if (ok_model[k]) dropq[k].push_back(cyc + 1);
         ok_model[k] = 1'b0;
         hold[k]     = DEFW;
      end
      rst = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      rst = 1'b0;
      chk("width_out after mid-pulse rst", 0, width_of(0), DEFW);
      repeat (447) @(negedge CLOCK_50);
      pwm_in[0] = 1'b0;
      repeat (500) @(negedge CLOCK_50);
      pulse(0, 600, 500);

      // 6: all channels, staggered, including both range limits
      fork
         pulse(0, 500, 1500);
         begin repeat (37)  @(negedge CLOCK_50); pulse(1, 625, 1300); end
         begin repeat (113) @(negedge CLOCK_50); pulse(2, 875, 1000); end
         begin repeat (260) @(negedge CLOCK_50); pulse(3, 1000, 800); end
      join
      fork
         pulse(0, 499, 1500);
         begin repeat (20) @(negedge CLOCK_50); pulse(1, 1001, 1200); end
         begin repeat (90) @(negedge CLOCK_50); pulse(2, 875, 1000); end
         begin repeat (50) @(negedge CLOCK_50); pulse(3, 500, 1400); end
      join
      for (int k = 0; k < NCH; k++) chk("multi-channel width_out", k, width_of(k), hold[k]);

      // 7: ch3 stuck high past the frame timeout; the others go quiet and time out too
      pwm_in[3]    = 1'b1;
      last_rise[3] = cyc + LAT;
      expect_timeouts();
      repeat (3600) @(negedge CLOCK_50);
      chk("stuck-high signal_ok", 3, signal_ok[3], 0);
      chk("stuck-high width held", 3, width_of(3), hold[3]);
      pwm_in[3] = 1'b0;
      repeat (200) @(negedge CLOCK_50);
      pulse(3, 720, 300);
      chk("recovered width_out", 3, width_of(3), 720);

      repeat (20) @(negedge CLOCK_50);
      for (int k = 0; k < NCH; k++) begin
         chk("outstanding strobes", k, evq[k].size(), 0);
         chk("outstanding drops", k, dropq[k].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
